// File: rtl/pong_pkg.sv
// Shared constants for the pong score display: 7-segment patterns in {g,f,e,d,c,b,a}
// order and the decoded-digit encoding used on both the driver and capture sides.
package pong_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_DASH = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: maps a displayed pattern back to its digit,
// flagging the all-off pattern and anything outside the table.
module seg7_decode
  import pong_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       is_blank_o,
  output logic       is_invalid_o
);

  always_comb begin
    digit_o      = 4'd0;
    is_blank_o   = 1'b0;
    is_invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_DASH:  digit_o = DIGIT_DASH;
      SEG_BLANK: is_blank_o = 1'b1;
      default:   is_invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/score_capture.sv
// Receive side of the multiplexed score display bus: synchronizes {cath,seg}, debounces,
// decodes each accepted pattern into the p1/p2 channel selected by cath, and detects game over.
module score_capture
  import pong_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_i,
  input  logic       cath_i,
  output logic [3:0] digit_p1_o,
  output logic [3:0] digit_p2_o,
  output logic       valid_p1_o,
  output logic       valid_p2_o,
  output logic       blank_p1_o,
  output logic       blank_p2_o,
  output logic       update_o,
  output logic       err_o,
  output logic       game_over_o
);

  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);

  logic [7:0]      sync_q [SYNC_STAGES];
  logic [7:0]      s;
  logic [7:0]      s_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_invalid;

  logic [1:0][3:0] digit_q, digit_d;
  logic [1:0]      valid_q, valid_d;
  logic [1:0]      blank_q, blank_d;
  logic            update_q, update_d;
  logic            err_q, err_d;
  logic            arm_q, arm_d;
  logic            game_over_q, game_over_d;
  logic            ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync_q[0] <= {cath_i, seg_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev_q <= s;
      cnt_q    <= cnt_d;
    end
  end

  assign s  = sync_q[SYNC_STAGES-1];
  assign ch = s[7];

  always_comb begin
    cnt_d = cnt_q;
    if (s != s_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STABLE_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires once per stable interval, on the step into saturation.
  assign accept = (s == s_prev_q) && (cnt_q == CntW'(STABLE_CNT - 1));

  seg7_decode u_decode (
    .seg_i        (s[6:0]),
    .digit_o      (dec_digit),
    .is_blank_o   (dec_blank),
    .is_invalid_o (dec_invalid)
  );

  always_comb begin
    digit_d     = digit_q;
    valid_d     = valid_q;
    blank_d     = blank_q;
    err_d       = err_q;
    update_d    = 1'b0;
    game_over_d = game_over_q;
    if (accept) begin
      if (dec_invalid) begin
        err_d = 1'b1;
      end else if (dec_blank) begin
        blank_d[ch] = 1'b1;
      end else begin
        digit_d[ch] = dec_digit;
        valid_d[ch] = 1'b1;
        blank_d[ch] = 1'b0;
        update_d    = (dec_digit != digit_q[ch]);
      end
    end
    // Armed while either held digit is a valid 9; drops once neither is.
    arm_d = (valid_d[0] && (digit_d[0] == 4'd9)) || (valid_d[1] && (digit_d[1] == 4'd9));
    if (!arm_d) begin
      game_over_d = 1'b0;
    end else if (arm_q && accept && dec_blank) begin
      game_over_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q     <= '0;
      valid_q     <= '0;
      blank_q     <= '0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      arm_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      update_q    <= update_d;
      err_q       <= err_d;
      arm_q       <= arm_d;
      game_over_q <= game_over_d;
    end
  end

  assign digit_p1_o  = digit_q[0];
  assign digit_p2_o  = digit_q[1];
  assign valid_p1_o  = valid_q[0];
  assign valid_p2_o  = valid_q[1];
  assign blank_p1_o  = blank_q[0];
  assign blank_p2_o  = blank_q[1];
  assign update_o    = update_q;
  assign err_o       = err_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_score_capture.sv
// Directed bench for score_capture: drives bus frames and compares outputs against
// hand-computed values.
module tb_score_capture;

  localparam logic [6:0] P0    = 7'b0111111;
  localparam logic [6:0] P1    = 7'b0000110;
  localparam logic [6:0] P3    = 7'b1001111;
  localparam logic [6:0] P4    = 7'b1100110;
  localparam logic [6:0] P5    = 7'b1101101;
  localparam logic [6:0] P8    = 7'b1111111;
  localparam logic [6:0] P9    = 7'b1101111;
  localparam logic [6:0] PDASH = 7'b1000000;
  localparam logic [6:0] PBLNK = 7'b0000000;
  localparam logic [6:0] PBAD  = 7'b0101010;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic       cath;
  logic [3:0] digit_p1, digit_p2;
  logic       valid_p1, valid_p2, blank_p1, blank_p2;
  logic       update, err, game_over;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;
  int snap;
  int first;
  int dummy;

  always #5 clk = ~clk;

  score_capture #(
    .SYNC_STAGES (2),
    .STABLE_CNT  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_i       (seg),
    .cath_i      (cath),
    .digit_p1_o  (digit_p1),
    .digit_p2_o  (digit_p2),
    .valid_p1_o  (valid_p1),
    .valid_p2_o  (valid_p2),
    .blank_p1_o  (blank_p1),
    .blank_p2_o  (blank_p2),
    .update_o    (update),
    .err_o       (err),
    .game_over_o (game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one bus value for n cycles; counts update pulses and reports the first one's cycle.
  task automatic drive(input logic c, input logic [6:0] p, input int n, output int first_o);
    first_o = 0;
    @(negedge clk);
    cath = c;
    seg  = p;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (update) begin
        upd_cnt++;
        if (first_o == 0) first_o = i;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    seg   = PBLNK;
    cath  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    seg   = PBLNK;
    cath  = 1'b0;
    #1;
    check_eq("rst_digit_p1", {28'd0, digit_p1}, 32'd0);
    check_eq("rst_valid_p1", {31'd0, valid_p1}, 32'd0);
    check_eq("rst_blank_p1", {31'd0, blank_p1}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset mid-stream with a held digit, then idle bus after release
    drive(1'b0, P5, 10, dummy);
    check_eq("p1_five", {28'd0, digit_p1}, 32'd5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_digit", {28'd0, digit_p1}, 32'd0);
    check_eq("midrst_valid", {31'd0, valid_p1}, 32'd0);
    check_eq("midrst_update_gover", {30'd0, update, game_over}, 32'd0);
    seg = PBLNK;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (blank_p1) break;
    end
    check_eq("idle_blank_p1", {31'd0, blank_p1}, 32'd1);
    check_eq("idle_digit_p1", {28'd0, digit_p1}, 32'd0);
    check_eq("idle_valid_p1", {31'd0, valid_p1}, 32'd0);

    // 2: normal alternating stream
    upd_cnt = 0;
    drive(1'b0, P3, 8, first);
    check_eq("first_upd_cycle", first, 32'd6);
    drive(1'b1, P4, 8, dummy);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, P3, 8, dummy);
      drive(1'b1, P4, 8, dummy);
    end
    check_eq("stream_digit_p1", {28'd0, digit_p1}, 32'd3);
    check_eq("stream_digit_p2", {28'd0, digit_p2}, 32'd4);
    check_eq("stream_valids", {30'd0, valid_p1, valid_p2}, 32'd3);
    check_eq("stream_upd_cnt", upd_cnt, 32'd2);

    // 3: glitch rejection then acceptance
    drive(1'b0, P0, 10, dummy);
    snap = upd_cnt;
    drive(1'b0, P8, 2, dummy);
    drive(1'b0, P0, 10, dummy);
    check_eq("glitch2_digit", {28'd0, digit_p1}, 32'd0);
    check_eq("glitch2_upd", upd_cnt - snap, 32'd0);
    snap = upd_cnt;
    drive(1'b0, P8, 4, dummy);
    drive(1'b0, P0, 3, dummy);
    check_eq("glitch4_digit", {28'd0, digit_p1}, 32'd8);
    check_eq("glitch4_upd", upd_cnt - snap, 32'd1);
    drive(1'b0, P0, 10, dummy);

    // 4: invalid pattern on p2
    check_eq("pre_err", {31'd0, err}, 32'd0);
    drive(1'b1, PBAD, 8, dummy);
    check_eq("bad_err", {31'd0, err}, 32'd1);
    check_eq("bad_digit_p2", {28'd0, digit_p2}, 32'd4);
    drive(1'b1, P4, 8, dummy);
    check_eq("err_sticky", {31'd0, err}, 32'd1);

    // 5: game over blink
    drive(1'b0, P9, 8, dummy);
    drive(1'b1, P1, 8, dummy);
    check_eq("gover_armed_only", {31'd0, game_over}, 32'd0);
    drive(1'b0, PBLNK, 8, dummy);
    check_eq("gover_set", {31'd0, game_over}, 32'd1);
    check_eq("gover_blank_p1", {31'd0, blank_p1}, 32'd1);
    check_eq("gover_held_digit", {28'd0, digit_p1}, 32'd9);
    drive(1'b1, PBLNK, 8, dummy);
    drive(1'b0, P9, 8, dummy);
    drive(1'b1, P1, 8, dummy);
    check_eq("gover_hold", {31'd0, game_over}, 32'd1);
    drive(1'b0, P0, 8, dummy);
    check_eq("gover_clear", {31'd0, game_over}, 32'd0);

    // 6: dash after a clean reset
    do_reset();
    drive(1'b0, PDASH, 8, dummy);
    check_eq("dash_digit", {28'd0, digit_p1}, 32'hF);
    check_eq("dash_valid", {31'd0, valid_p1}, 32'd1);
    check_eq("dash_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_capture.md
Name: score_capture

Overview:
- Receive side of the multiplexed score display bus (seg_a..seg_g plus cath).
- Samples the bus asynchronously to the display driver's clock and demultiplexes by cath: cath=0 is player 1, cath=1 is player 2.
- Debounces each pattern, decodes it back to a BCD digit, and detects the game-over blink.
- Sits in test harnesses and in the on-board readback/self-check path. Capture clk must run at least 2*(SYNC_STAGES+STABLE_CNT) times faster than the driver's cath toggle rate.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer for the 8 bus bits (minimum 2).
- STABLE_CNT, 3, number of consecutive identical synchronized samples (seg and cath) required to accept a pattern (minimum 1).

Ports:
- clk  in  1  capture clock.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  segment bus {g,f,e,d,c,b,a}; bit0 = seg_a.
- cath  in  1  digit select from the display driver; 0 = p1, 1 = p2.
- digit_p1  out  4  last accepted p1 digit, 0-9; 4'hF = dash pattern.
- digit_p2  out  4  same for p2.
- valid_p1  out  1  set once p1 has accepted a non-blank, non-error pattern.
- valid_p2  out  1  same for p2.
- blank_p1  out  1  last accepted p1 pattern was all-off.
- blank_p2  out  1  same for p2.
- update  out  1  one-cycle pulse when digit_p1 or digit_p2 changes value.
- err  out  1  sticky; set on any accepted pattern not in the decode table.
- game_over  out  1  blink detected (see rules below).

Behaviour:
- Reset (async): all synchronizer flops, counters and outputs go to 0. digit_* = 0, valid/blank/update/err/game_over = 0.
- Synchronizer: {cath,seg} passes through SYNC_STAGES flops. Only the final stage, s, is used; s_prev is s delayed one cycle.
- Stability counter (width clog2(STABLE_CNT+1)):
  - cnt <= 0 when s != s_prev.
  - Otherwise cnt <= cnt+1, saturating at STABLE_CNT.
- Accept strobe: fires on the single cycle where cnt transitions to STABLE_CNT-1 → STABLE_CNT with s == s_prev. With STABLE_CNT=1, it fires on the first repeated sample.
  - A pattern is accepted exactly once per stable interval.
  - Glitches shorter than STABLE_CNT+1 samples are never accepted.
- Accepted pattern routed by s.cath to the p1 or p2 channel. Registered outputs update on the clk edge following the accept strobe.
- Latency: from the first capture edge sampling a new stable bus value to the output change = SYNC_STAGES + STABLE_CNT + 1 cycles.
- Decode table (pattern {g..a} → digit):
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
  - 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9
  - 1000000→F (dash)
- Decoded digit (0-9 or F): digit_x <= value, valid_x <= 1, blank_x <= 0. update pulses the next cycle only if the value differs from the previously held digit_x.
- All-off 0000000: digit_x held, blank_x <= 1, valid_x unchanged, no update pulse.
- Any other pattern: digit_x, valid_x and blank_x held; err <= 1 (sticky until reset).
- update: if both channels change on consecutive accepts, each gets its own pulse. update is never high for 2 consecutive cycles, because accepts are at least STABLE_CNT+1 cycles apart.
- Game-over tracking:
  - gover_arm sets when either channel accepts digit 9 while valid. It clears when both held digits are <9 or F.
  - game_over <= 1 when gover_arm=1 and a blank is accepted on either channel.
  - game_over clears when gover_arm clears.
- No state machine beyond the per-channel hold registers, counter and arm flag. A mid-frame cath change simply restarts the counter.

Decomposition:
- Shared package pong_pkg:
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK as 7-bit localparams in {g..a} order, shared with the display driver.
  - DIGIT_DASH = 4'hF.
- One natural sub-module: seg7_decode, purely combinational. Pattern in → {digit[3:0], is_blank, is_invalid}.
- Synchronizer, stability counter and channel registers stay in score_capture.

Test Plan:
1. Reset check: assert reset mid-stream with digit_p1=5 held → all outputs 0 within the same cycle. After release with bus idle at 0000000, blank_p1=1 after 2+3+1 cycles; digit stays 0 and valid stays 0.
2. Normal stream: alternate cath every 8 clk with p1=1001111 and p2=1100110.
   - digit_p1=3 and digit_p2=4, valid both 1.
   - Exactly 2 update pulses, first at cycle 6 after the p1 pattern appears.
   - Steady repeats produce no further pulses.
3. Glitch rejection: hold p1=0111111, inject 1111111 for 2 clk, then return → digit_p1 stays 0, no update. Inject it for 4 clk → digit_p1=8 and update pulses.
4. Invalid pattern: p2=0101010 stable 8 clk → err=1, digit_p2 unchanged. err stays 1 after valid patterns resume.
5. Game over: p1=1101111 (9), p2=0000110, then both blank for 16 clk, then restored → game_over=1 after the first accepted blank. Subsequently drive p1=0111111 → game_over=0.
6. Dash: p1=1000000 → digit_p1=F, valid_p1=1, err=0.
